// File: rtl/parking_pkg.sv
// Shared constants, slot-vector type and occupancy helpers for the parking controller.
package parking_pkg;

    localparam int unsigned N_SLOTS = 4;
    // 100 Hz -> 2 Hz and 2 Hz -> 1 Hz divisors
    localparam int unsigned DIV_2HZ = 50;
    localparam int unsigned DIV_1HZ = 2;

    typedef logic [N_SLOTS-1:0] slots_t;

    // One-hot of the lowest clear bit; zero when every slot is occupied
    function automatic slots_t lowest_free(input slots_t s);
        return ~s & (s + slots_t'(1));
    endfunction

    // Number of free slots
    function automatic logic [2:0] free_count(input slots_t s);
        logic [2:0] n;
        n = 3'(N_SLOTS);
        for (int i = 0; i < N_SLOTS; i++) begin
            n = n - {2'b00, s[i]};
        end
        return n;
    endfunction

    // Lowest free slot index plus one; zero when full
    function automatic logic [2:0] best_index(input slots_t s);
        logic [2:0] b;
        b = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!s[i]) b = 3'(i + 1);
        end
        return b;
    endfunction

endpackage

// File: rtl/parking_tick_gen.sv
// Clock-enable divider: 100 Hz, 2 Hz and 1 Hz single-cycle pulses, all registered
// so that slower ticks coincide with the 100 Hz tick that completes them.
module parking_tick_gen
    import parking_pkg::*;
#(
    parameter int unsigned CLK_HZ = 40000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_100hz,
    output logic tick_2hz,
    output logic tick_1hz
);

    localparam int unsigned DIV_100HZ = CLK_HZ / 100;
    localparam int unsigned CNT_W     = (DIV_100HZ > 1) ? $clog2(DIV_100HZ) : 1;
    localparam int unsigned C2_W      = $clog2(DIV_2HZ);
    localparam int unsigned C1_W      = (DIV_1HZ > 1) ? $clog2(DIV_1HZ) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_100HZ - 1);
    localparam logic [C2_W-1:0]  C2_LAST  = C2_W'(DIV_2HZ - 1);
    localparam logic [C1_W-1:0]  C1_LAST  = C1_W'(DIV_1HZ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [C2_W-1:0]  c2_q, c2_d;
    logic [C1_W-1:0]  c1_q, c1_d;
    logic             wrap_100, wrap_2, wrap_1;

    // Cascaded wrap detection and counter next state
    always_comb begin
        wrap_100 = (cnt_q == CNT_LAST);
        wrap_2   = wrap_100 && (c2_q == C2_LAST);
        wrap_1   = wrap_2 && (c1_q == C1_LAST);
        cnt_d    = wrap_100 ? '0 : cnt_q + CNT_W'(1);
        c2_d     = c2_q;
        c1_d     = c1_q;
        if (wrap_100) c2_d = wrap_2 ? '0 : c2_q + C2_W'(1);
        if (wrap_2)   c1_d = wrap_1 ? '0 : c1_q + C1_W'(1);
    end

    // Counter and tick registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            c2_q       <= '0;
            c1_q       <= '0;
            tick_100hz <= 1'b0;
            tick_2hz   <= 1'b0;
            tick_1hz   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            c2_q       <= c2_d;
            c1_q       <= c1_d;
            tick_100hz <= wrap_100;
            tick_2hz   <= wrap_2;
            tick_1hz   <= wrap_1;
        end
    end

endmodule

// File: rtl/parking_controller.sv
// Four-slot parking controller: synchronised entry/exit sensors, occupancy tracking,
// free-slot reporting and a door light.
// Build option PARKING_DOOR_HOLD_EN: door light held for DOOR_HOLD_S 1 Hz ticks after
// each accepted event; otherwise it is a single-cycle pulse.
module parking_controller
    import parking_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 40000000,
    parameter int unsigned DOOR_HOLD_S = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_sensor,
    input  logic       exit_sensor,
    input  logic [1:0] switch,
    output logic [3:0] parking_slots,
    output logic [2:0] capacity,
    output logic [2:0] best_place,
    output logic       full_light,
    output logic       door_open_light,
    output logic       tick_100hz,
    output logic       tick_2hz,
    output logic       tick_1hz
);

    logic   entry_meta_q, entry_sync_q, entry_prev_q;
    logic   exit_meta_q, exit_sync_q, exit_prev_q;
    logic   entry_edge, exit_edge;
    slots_t slots_q, slots_d, slots_mid, entry_onehot;
    logic   exit_ok, entry_ok, accepted;
    logic   door_q;

    parking_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .tick_100hz(tick_100hz),
        .tick_2hz  (tick_2hz),
        .tick_1hz  (tick_1hz)
    );

    // Two-flop synchronisers plus a history flop for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_meta_q <= 1'b0;
            entry_sync_q <= 1'b0;
            entry_prev_q <= 1'b0;
            exit_meta_q  <= 1'b0;
            exit_sync_q  <= 1'b0;
            exit_prev_q  <= 1'b0;
        end else begin
            entry_meta_q <= entry_sensor;
            entry_sync_q <= entry_meta_q;
            entry_prev_q <= entry_sync_q;
            exit_meta_q  <= exit_sensor;
            exit_sync_q  <= exit_meta_q;
            exit_prev_q  <= exit_sync_q;
        end
    end

    assign entry_edge = entry_sync_q & ~entry_prev_q;
    assign exit_edge  = exit_sync_q & ~exit_prev_q;

    // Occupancy next state: exit is applied first so a full lot can admit a
    // car arriving in the same cycle
    always_comb begin
        slots_mid = slots_q;
        exit_ok   = exit_edge & slots_q[switch];
        if (exit_ok) slots_mid[switch] = 1'b0;
        entry_onehot = entry_edge ? lowest_free(slots_mid) : '0;
        entry_ok     = |entry_onehot;
        slots_d      = slots_mid | entry_onehot;
        accepted     = exit_ok | entry_ok;
    end

    // Occupancy register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) slots_q <= '0;
        else     slots_q <= slots_d;
    end

`ifdef PARKING_DOOR_HOLD_EN
    localparam int unsigned HOLD_W = (DOOR_HOLD_S > 0) ? $clog2(DOOR_HOLD_S + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(DOOR_HOLD_S);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              door_d;

    // Hold countdown: a new accepted event restarts it, each 1 Hz tick consumes one
    always_comb begin
        hold_d = hold_q;
        door_d = door_q;
        if (accepted) begin
            hold_d = HOLD_INIT;
            door_d = 1'b1;
        end else if (door_q && tick_1hz) begin
            if (hold_q <= HOLD_W'(1)) begin
                hold_d = '0;
                door_d = 1'b0;
            end else begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end
    end

    // Door light and hold counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            door_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            door_q <= door_d;
        end
    end
`else
    logic unused_door_hold;
    assign unused_door_hold = ^DOOR_HOLD_S;

    // Door light pulses for one cycle after each accepted event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) door_q <= 1'b0;
        else     door_q <= accepted;
    end
`endif

    assign parking_slots   = slots_q;
    assign capacity        = free_count(slots_q);
    assign best_place      = best_index(slots_q);
    assign full_light      = (&slots_q) & entry_sync_q & ~exit_sync_q;
    assign door_open_light = door_q;

endmodule

// File: tb/tb_parking_controller.sv
// Self-checking bench for parking_controller (CLK_HZ=1000, DOOR_HOLD_S=2) with a
// slot-array reference model.
module tb_parking_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_sensor = 1'b0;
    logic       exit_sensor = 1'b0;
    logic [1:0] switch = 2'd0;
    logic [3:0] parking_slots;
    logic [2:0] capacity;
    logic [2:0] best_place;
    logic       full_light;
    logic       door_open_light;
    logic       tick_100hz;
    logic       tick_2hz;
    logic       tick_1hz;

    int total = 0;
    int bad = 0;

    // Reference model: occupancy of each slot
    bit m_occ[4];

    parking_controller #(
        .CLK_HZ     (1000),
        .DOOR_HOLD_S(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .entry_sensor   (entry_sensor),
        .exit_sensor    (exit_sensor),
        .switch         (switch),
        .parking_slots  (parking_slots),
        .capacity       (capacity),
        .best_place     (best_place),
        .full_light     (full_light),
        .door_open_light(door_open_light),
        .tick_100hz     (tick_100hz),
        .tick_2hz       (tick_2hz),
        .tick_1hz       (tick_1hz)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_occ[i];
        return v;
    endfunction

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < 4; i++) if (!m_occ[i]) n++;
        return n;
    endfunction

    function automatic int m_best();
        for (int i = 0; i < 4; i++) if (!m_occ[i]) return i + 1;
        return 0;
    endfunction

    function automatic bit m_full();
        return m_occ[0] && m_occ[1] && m_occ[2] && m_occ[3];
    endfunction

    task automatic model_apply(input bit ent, input bit ext, input logic [1:0] sw,
                               output bit acc);
        acc = 1'b0;
        if (ext && m_occ[sw]) begin
            m_occ[sw] = 1'b0;
            acc = 1'b1;
        end
        if (ent) begin
            for (int i = 0; i < 4; i++) begin
                if (!m_occ[i]) begin
                    m_occ[i] = 1'b1;
                    acc = 1'b1;
                    break;
                end
            end
        end
    endtask

    // Raise sensors and return just after the edge where the event takes effect
    task automatic pulse(input bit ent, input bit ext, input logic [1:0] sw);
        @(negedge clk);
        switch = sw;
        entry_sensor = ent;
        exit_sensor = ext;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_sensors();
        @(negedge clk);
        entry_sensor = 1'b0;
        exit_sensor = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (parking_slots !== 4'b0000) begin
            bad++; $display("FAIL reset_slots: got %b want 0000", parking_slots);
        end
        total++;
        if (capacity !== 3'd4 || best_place !== 3'd1 || full_light !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: got cap=%0d best=%0d full=%b want cap=4 best=1 full=0",
                     capacity, best_place, full_light);
        end
        total++;
        if ({door_open_light, tick_100hz, tick_2hz, tick_1hz} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_lights: got door/ticks=%b want 0000",
                     {door_open_light, tick_100hz, tick_2hz, tick_1hz});
        end
        for (int i = 0; i < 4; i++) m_occ[i] = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_fill();
        bit acc;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            switch = 2'd0;
            entry_sensor = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            total++;
            if (parking_slots !== m_vec()) begin
                bad++; $display("FAIL fill_latency_%0d: got %b want %b", k, parking_slots, m_vec());
            end
            @(posedge clk);
            #1;
            model_apply(1'b1, 1'b0, 2'd0, acc);
            total++;
            if (parking_slots !== m_vec() || capacity !== 3'(m_free())
                || best_place !== 3'(m_best())) begin
                bad++;
                $display("FAIL fill_%0d: got slots=%b cap=%0d best=%0d want %b %0d %0d", k,
                         parking_slots, capacity, best_place, m_vec(), m_free(), m_best());
            end
            total++;
            if (door_open_light !== acc) begin
                bad++; $display("FAIL fill_door_%0d: got %b want %b", k, door_open_light, acc);
            end
            release_sensors();
        end
    endtask

    task automatic test_full_refused();
        bit acc;
        for (int i = 0; i < 2500 && door_open_light; i++) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (door_open_light !== 1'b0) begin
            bad++; $display("FAIL refused_door_idle: got %b want 0", door_open_light);
        end
        pulse(1'b1, 1'b0, 2'd0);
        model_apply(1'b1, 1'b0, 2'd0, acc);
        total++;
        if (full_light !== 1'b1) begin
            bad++; $display("FAIL refused_full_light: got %b want 1", full_light);
        end
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (parking_slots !== m_vec() || door_open_light !== acc) begin
            bad++;
            $display("FAIL refused_state: got slots=%b door=%b want %b %b",
                     parking_slots, door_open_light, m_vec(), acc);
        end
        release_sensors();
    endtask

    task automatic test_simultaneous();
        bit acc;
        pulse(1'b1, 1'b1, 2'd2);
        model_apply(1'b1, 1'b1, 2'd2, acc);
        total++;
        if (parking_slots !== m_vec() || door_open_light !== acc) begin
            bad++;
            $display("FAIL simul_state: got slots=%b door=%b want %b %b",
                     parking_slots, door_open_light, m_vec(), acc);
        end
        total++;
        if (full_light !== 1'b0) begin
            bad++; $display("FAIL simul_full_light: got %b want 0", full_light);
        end
        release_sensors();
    endtask

    task automatic test_exit_empty();
        bit acc;
        pulse(1'b0, 1'b1, 2'd1);
        model_apply(1'b0, 1'b1, 2'd1, acc);
        release_sensors();
        pulse(1'b0, 1'b1, 2'd3);
        model_apply(1'b0, 1'b1, 2'd3, acc);
        release_sensors();
        total++;
        if (parking_slots !== 4'b0101 || parking_slots !== m_vec()) begin
            bad++; $display("FAIL exit_setup: got %b want 0101", parking_slots);
        end
        for (int i = 0; i < 2500 && door_open_light; i++) begin
            @(posedge clk);
            #1;
        end
        pulse(1'b0, 1'b1, 2'd1);
        model_apply(1'b0, 1'b1, 2'd1, acc);
        @(posedge clk);
        #1;
        total++;
        if (parking_slots !== m_vec() || door_open_light !== acc) begin
            bad++;
            $display("FAIL exit_empty: got slots=%b door=%b want %b %b",
                     parking_slots, door_open_light, m_vec(), acc);
        end
        release_sensors();
        pulse(1'b0, 1'b1, 2'd0);
        model_apply(1'b0, 1'b1, 2'd0, acc);
        total++;
        if (parking_slots !== m_vec() || capacity !== 3'(m_free())) begin
            bad++;
            $display("FAIL exit_slot0: got slots=%b cap=%0d want %b %0d",
                     parking_slots, capacity, m_vec(), m_free());
        end
        release_sensors();
    endtask

    task automatic test_door();
        bit acc;
        int ticks;
        for (int i = 0; i < 2500 && door_open_light; i++) begin
            @(posedge clk);
            #1;
        end
        pulse(1'b1, 1'b0, 2'd0);
        model_apply(1'b1, 1'b0, 2'd0, acc);
        total++;
        if (door_open_light !== acc) begin
            bad++; $display("FAIL door_rise: got %b want %b", door_open_light, acc);
        end
`ifdef PARKING_DOOR_HOLD_EN
        release_sensors();
        ticks = 0;
        for (int i = 0; i < 2600 && door_open_light; i++) begin
            @(posedge clk);
            #1;
            if (tick_1hz) ticks++;
        end
        total++;
        if (door_open_light !== 1'b0 || ticks != 2) begin
            bad++;
            $display("FAIL door_hold: got door=%b ticks=%0d want door=0 ticks=2",
                     door_open_light, ticks);
        end
`else
        ticks = 0;
        @(posedge clk);
        #1;
        total++;
        if (door_open_light !== 1'b0) begin
            bad++; $display("FAIL door_pulse: got %b want 0 (ticks=%0d)", door_open_light, ticks);
        end
        release_sensors();
`endif
    endtask

    task automatic test_random();
        bit acc, ent, ext;
        logic [1:0] sw;
        for (int k = 0; k < 40; k++) begin
            ent = 1'($urandom_range(0, 1));
            ext = 1'($urandom_range(0, 1));
            if (!ent && !ext) ent = 1'b1;
            sw = 2'($urandom_range(0, 3));
            pulse(ent, ext, sw);
            model_apply(ent, ext, sw, acc);
            total++;
            if (parking_slots !== m_vec() || capacity !== 3'(m_free())
                || best_place !== 3'(m_best())) begin
                bad++;
                $display("FAIL rand_%0d: got slots=%b cap=%0d best=%0d want %b %0d %0d", k,
                         parking_slots, capacity, best_place, m_vec(), m_free(), m_best());
            end
            total++;
            if (full_light !== (m_full() && ent && !ext)) begin
                bad++;
                $display("FAIL rand_full_%0d: got %b want %b", k, full_light,
                         (m_full() && ent && !ext));
            end
`ifdef PARKING_DOOR_HOLD_EN
            if (acc) begin
                total++;
                if (door_open_light !== 1'b1) begin
                    bad++; $display("FAIL rand_door_%0d: got %b want 1", k, door_open_light);
                end
            end
`else
            total++;
            if (door_open_light !== acc) begin
                bad++; $display("FAIL rand_door_%0d: got %b want %b", k, door_open_light, acc);
            end
`endif
            release_sensors();
        end
    endtask

    task automatic test_reset_mid_hold();
        bit acc;
        if (m_full()) begin
            pulse(1'b0, 1'b1, 2'd0);
            model_apply(1'b0, 1'b1, 2'd0, acc);
        end else begin
            pulse(1'b1, 1'b0, 2'd0);
            model_apply(1'b1, 1'b0, 2'd0, acc);
        end
        total++;
        if (door_open_light !== 1'b1) begin
            bad++; $display("FAIL midhold_door_on: got %b want 1", door_open_light);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        entry_sensor = 1'b0;
        exit_sensor = 1'b0;
        #1;
        total++;
        if (door_open_light !== 1'b0 || parking_slots !== 4'b0000 || capacity !== 3'd4) begin
            bad++;
            $display("FAIL midhold_reset: got door=%b slots=%b cap=%0d want 0 0000 4",
                     door_open_light, parking_slots, capacity);
        end
        for (int i = 0; i < 4; i++) m_occ[i] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_divider();
        int q100[$];
        int q2[$];
        int q1[$];
        int off = 0;
        bit coinc = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 1010; n++) begin
            @(posedge clk);
            #1;
            if (tick_100hz) q100.push_back(n);
            if (tick_2hz) q2.push_back(n);
            if (tick_1hz) q1.push_back(n);
            if (n == 1000) coinc = tick_100hz && tick_2hz && tick_1hz;
        end
        foreach (q100[i]) if (q100[i] != 10 * (i + 1)) off++;
        total++;
        if (q100.size() != 101 || off != 0) begin
            bad++;
            $display("FAIL div_100hz: got count=%0d misplaced=%0d want 101 0", q100.size(), off);
        end
        total++;
        if (q2.size() != 2 || (q2.size() == 2 && (q2[0] != 500 || q2[1] != 1000))) begin
            bad++;
            $display("FAIL div_2hz: got count=%0d first=%0d want 2 pulses at 500,1000",
                     q2.size(), (q2.size() > 0) ? q2[0] : -1);
        end
        total++;
        if (q1.size() != 1 || (q1.size() == 1 && q1[0] != 1000)) begin
            bad++;
            $display("FAIL div_1hz: got count=%0d first=%0d want 1 pulse at 1000",
                     q1.size(), (q1.size() > 0) ? q1[0] : -1);
        end
        total++;
        if (coinc !== 1'b1) begin
            bad++; $display("FAIL div_coincident: got %b want 1", coinc);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_refused();
        test_simultaneous();
        test_exit_empty();
        test_door();
        test_random();
        test_reset_mid_hold();
        test_divider();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_controller.md
PARKING_CONTROLLER -- requirements
Module: parking_controller

Interface
REQ-001 SHALL have parameter CLK_HZ, default 40000000, input clock frequency in Hz; multiple of 100, at least 100.
REQ-002 SHALL have parameter DOOR_HOLD_S, default 2, door-light hold time in 1 Hz ticks.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port entry_sensor, input, 1, car at entrance; asynchronous level.
REQ-006 SHALL have port exit_sensor, input, 1, car at exit; asynchronous level.
REQ-007 SHALL have port switch, input, 2, index 0..3 of the slot being vacated.
REQ-008 SHALL have port parking_slots, output, 4, occupancy; bit i=1 means slot i is occupied.
REQ-009 SHALL have port capacity, output, 3, number of free slots, 0..4.
REQ-010 SHALL have port best_place, output, 3, lowest free slot index+1 (1..4); 0 when full.
REQ-011 SHALL have port full_light, output, 1, entry refused indicator.
REQ-012 SHALL have port door_open_light, output, 1, accepted-event indicator.
REQ-013 SHALL have ports tick_100hz, tick_2hz and tick_1hz, output, 1 each, single-cycle clock-enable pulses.

Function
REQ-014 SHALL pass each sensor through a 2-flop synchronizer, then a rising-edge detector (third flop); the edge is valid 3 clk edges after the input goes high.
REQ-015 SHALL, on a valid exit edge, clear parking_slots[switch] if set; exit to an empty slot SHALL be ignored.
REQ-016 SHALL, on a valid entry edge, set the lowest-index free slot; entry when all 4 slots are occupied SHALL be ignored.
REQ-017 SHALL, when entry and exit edges coincide, apply the exit first and then the entry in the same cycle, so a full lot accepts the car.
REQ-018 SHALL update parking_slots on the clock edge where the sensor edge is valid.
REQ-019 SHALL derive capacity and best_place combinationally from parking_slots as 4-popcount and priority encode respectively.
REQ-020 SHALL drive full_light = (all slots occupied) AND synchronized entry level AND NOT synchronized exit level, combinationally.
REQ-021 SHALL assert door_open_light from the cycle after any accepted entry or exit until DOOR_HOLD_S tick_1hz pulses have elapsed; a new accepted event SHALL restart the hold.
REQ-022 SHALL pulse tick_100hz once every CLK_HZ/100 clk cycles; the first pulse SHALL occur on cycle CLK_HZ/100 after reset release.
REQ-023 SHALL pulse tick_2hz on every 50th tick_100hz, coincident with it.
REQ-024 SHALL pulse tick_1hz on every 2nd tick_2hz, coincident with it.

Reset
REQ-025 SHALL, on rst, clear parking_slots, all sync and edge flops, divider counters, hold counter, door_open_light and all ticks.
REQ-026 SHALL hold capacity=4, best_place=1 and full_light=0 during reset.
REQ-027 SHALL abort any door-open hold on reset asserted mid-operation and discard pending edges.

Configuration
REQ-028 SHALL support macro PARKING_DOOR_HOLD_EN: when defined, door_open_light follows REQ-021; when undefined, door_open_light is a single-cycle pulse in the cycle after an accepted event and DOOR_HOLD_S is unused.

Structure
REQ-029 SHALL place N_SLOTS=4, the slot-vector typedef, and the divisor constants 50 and 2 in the shared package parking_pkg.
REQ-030 SHALL implement the tick divider as sub-module parking_tick_gen; the occupancy FSM and capacity logic stay in the top.

Verification (CLK_HZ=1000, DOOR_HOLD_S=2)
REQ-031 SHALL cover reset then 4 entry pulses: parking_slots 0001,0011,0111,1111; capacity 3,2,1,0; best_place 2,3,4,0.
REQ-032 SHALL cover a full lot with entry held and exit low: full_light=1, slots unchanged, door_open_light stays 0.
REQ-033 SHALL cover a full lot with switch=2 and simultaneous entry and exit edges: slots stay 1111, door_open_light=1, full_light=0.
REQ-034 SHALL cover an exit with switch=1 on slots 0101: no change and no door pulse; then switch=0 gives slots 0100, capacity 3.
REQ-035 SHALL cover the divider: tick_100hz every 10 cycles, tick_2hz every 500, tick_1hz every 1000, all coincident at cycle 1000.
REQ-036 SHALL cover rst asserted mid-hold: door_open_light=0 and slots=0000 immediately, without waiting for a clock edge.
